key_press_gen: RTL

KEY_PRESS_GEN -- requirements
Module: key_press_gen

---
 rtl/key_gen_pkg.sv | 18 +
 rtl/phase_timer.sv | 35 +++
 rtl/key_press_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_gen_pkg.sv
// Shared definitions for the key press generator: FSM state encoding,
// default phase lengths and the phase counter width.
package key_gen_pkg;

  localparam int unsigned CNT_W             = 8;
  localparam int unsigned DEF_HOLD_CYCLES   = 8;
  localparam int unsigned DEF_GAP_CYCLES    = 4;
  localparam int unsigned DEF_BOUNCE_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE,
    B_PRESS,
    HOLD,
    B_RELEASE,
    GAP
  } key_state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable phase down-counter: load takes priority, otherwise count down
// and stick at zero.
module phase_timer
  import key_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/key_press_gen.sv
// Emulated push-button: one key press per request, with a one-deep pending
// queue. Define KEY_PRESS_GEN_BOUNCE_EN to add contact chatter on each edge.
module key_press_gen
  import key_gen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned BOUNCE_CYCLES = DEF_BOUNCE_CYCLES
) (
  input  logic debounce_clk,
  input  logic rst,
  input  logic req,
  output logic key,
  output logic busy,
  output logic done,
  output logic overflow
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 15) begin : g_bad_param
    $error("key_press_gen: parameter out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
`ifdef KEY_PRESS_GEN_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES - 1);
`endif

  key_state_e       state_q, state_d;
  logic             key_q, key_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  phase_timer u_timer (
    .clk      (debounce_clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == GAP) && zero;
  assign key      = key_q;
  assign overflow = overflow_q;

  // key_d is the level for the next cycle, so chatter is produced by
  // toggling the registered level while the bounce phase is still running.
  always_comb begin
    state_d    = state_q;
    key_d      = 1'b0;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    load       = 1'b0;
    load_val   = '0;

    if (req && busy) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req) begin
          load  = 1'b1;
          key_d = 1'b1;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
          state_d  = B_PRESS;
          load_val = BOUNCE_LD;
`else
          state_d  = HOLD;
          load_val = HOLD_LD;
`endif
        end
      end
`ifdef KEY_PRESS_GEN_BOUNCE_EN
      B_PRESS: begin
        if (zero) begin
          state_d  = HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
          key_d    = 1'b1;
        end else begin
          key_d = ~key_q;
        end
      end
      B_RELEASE: begin
        if (zero) begin
          state_d  = GAP;
          load     = 1'b1;
          load_val = GAP_LD;
        end else begin
          key_d = ~key_q;
        end
      end
`endif
      HOLD: begin
        if (zero) begin
          load = 1'b1;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
          state_d  = B_RELEASE;
          load_val = BOUNCE_LD;
`else
          state_d  = GAP;
          load_val = GAP_LD;
`endif
        end else begin
          key_d = 1'b1;
        end
      end
      GAP: begin
        if (zero) begin
          // A req in this very cycle counts as pending and is served at once.
          if (pending_q || req) begin
            pending_d = 1'b0;
            load      = 1'b1;
            key_d     = 1'b1;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
            state_d  = B_PRESS;
            load_val = BOUNCE_LD;
`else
            state_d  = HOLD;
            load_val = HOLD_LD;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge debounce_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
